// File: rtl/bs_gnrtr_n_rbtr.sv
// bs_gnrtr_n_rbtr: shared-bus generator and round-robin arbiter.
// Each of `bits` lanes joins `drvrs` device ports. Per lane, a
// three-state FSM (IDLE -> POP -> PUSH) grants one pending port,
// pops its head packet and delivers it to the destination port(s).
// Optional feature macro: BS_BROADCAST_EN (broadcast ID replicates the
// packet to every port except the source; otherwise it is dropped).
//
// Handshake: pndng[l][p] acts as "valid" for D_pop[l][p]. pop[l][p] is a
// one-cycle strobe meaning "head consumed"; the FIFO advances on the
// rising edge that ends the pop cycle. push[l][p] is a one-cycle write
// strobe qualifying D_push[l][p]; receivers are assumed always ready.
module bs_gnrtr_n_rbtr #(
    parameter int          bits      = 1,
    parameter int          drvrs     = 4,
    parameter int          pckg_sz   = 16,
    parameter logic [7:0]  broadcast = 8'hFF
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [bits-1:0][drvrs-1:0]                pndng,
    input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]   D_pop,
    output logic [bits-1:0][drvrs-1:0]                pop,
    output logic [bits-1:0][drvrs-1:0]                push,
    output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]   D_push,
    output logic [bits-1:0][1:0]                      o_dbg_state
);

    localparam int PW = (drvrs > 1) ? $clog2(drvrs) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_POP  = 2'd1;
    localparam logic [1:0] ST_PUSH = 2'd2;

    for (genvar l = 0; l < bits; l++) begin : g_lane
        logic [1:0]         r_state;
        logic [PW-1:0]      r_src;
        logic [PW-1:0]      r_ptr;
        logic [pckg_sz-1:0] r_pkt;
        logic [pckg_sz-1:0] r_dpush;
        logic [drvrs-1:0]   r_pop;
        logic [drvrs-1:0]   r_push;

        logic [PW-1:0]      w_win;
        logic               w_any;
        logic [7:0]         w_dest;
        logic [drvrs-1:0]   w_one;
        logic [drvrs-1:0]   w_push_dec;

        // Round-robin winner: first pending port after the pointer, wrapping.
        // Scanning from the farthest candidate down lets the nearest one win.
        always_comb begin
            w_win = '0;
            w_any = 1'b0;
            for (int k = drvrs; k >= 1; k--) begin
                int idx;
                idx = (int'(r_ptr) + k) % drvrs;
                if (pndng[l][idx]) begin
                    w_win = PW'(idx);
                    w_any = 1'b1;
                end
            end
        end

        // Destination decode of the latched packet into a push mask.
        always_comb begin
            w_dest     = r_pkt[pckg_sz-1 -: 8];
            w_one      = '0;
            w_one[0]   = 1'b1;
            w_push_dec = '0;
`ifdef BS_BROADCAST_EN
            if (w_dest == broadcast)
                w_push_dec = ~(w_one << r_src);
            else
`endif
            if (int'(w_dest) < drvrs)
                w_push_dec = w_one << w_dest;
        end

        // Lane FSM; every output is a register updated alongside the state.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_state <= ST_IDLE;
                r_src   <= '0;
                r_ptr   <= PW'(drvrs - 1);
                r_pkt   <= '0;
                r_dpush <= '0;
                r_pop   <= '0;
                r_push  <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_pop  <= '0;
                        r_push <= '0;
                        if (w_any) begin
                            r_src   <= w_win;
                            r_ptr   <= w_win;
                            r_pkt   <= D_pop[l][w_win];
                            r_pop   <= w_one << w_win;
                            r_state <= ST_POP;
                        end
                    end
                    ST_POP: begin
                        // Dropped packets still load D_push; only push stays 0.
                        r_pop   <= '0;
                        r_push  <= w_push_dec;
                        r_dpush <= r_pkt;
                        r_state <= ST_PUSH;
                    end
                    ST_PUSH: begin
                        r_pop   <= '0;
                        r_push  <= '0;
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_pop   <= '0;
                        r_push  <= '0;
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end

        assign pop[l]         = r_pop;
        assign push[l]        = r_push;
        assign o_dbg_state[l] = r_state;

        for (genvar p = 0; p < drvrs; p++) begin : g_port
            assign D_push[l][p] = r_dpush;
        end
    end

endmodule

// File: tb/tb_bs_gnrtr_n_rbtr.sv
// Testbench for bs_gnrtr_n_rbtr (one lane, four ports, 16-bit packets).
// Honours BS_BROADCAST_EN when choosing broadcast expectations.
module tb_bs_gnrtr_n_rbtr;

  localparam int BITS = 1;
  localparam int DRV  = 4;
  localparam int PSZ  = 16;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [BITS-1:0][DRV-1:0]          pndng;
  logic [BITS-1:0][DRV-1:0][PSZ-1:0] D_pop;
  logic [BITS-1:0][DRV-1:0]          pop;
  logic [BITS-1:0][DRV-1:0]          push;
  logic [BITS-1:0][DRV-1:0][PSZ-1:0] D_push;
  logic [BITS-1:0][1:0]              dbg_state;

  bs_gnrtr_n_rbtr #(
    .bits(BITS), .drvrs(DRV), .pckg_sz(PSZ), .broadcast(8'hFF)
  ) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop),
    .pop(pop), .push(push), .D_push(D_push), .o_dbg_state(dbg_state)
  );

`ifdef BS_BROADCAST_EN
  localparam logic [3:0] BC_FROM2 = 4'b1011;
  localparam logic [3:0] BC_FROM3 = 4'b0111;
`else
  localparam logic [3:0] BC_FROM2 = 4'b0000;
  localparam logic [3:0] BC_FROM3 = 4'b0000;
`endif

  typedef struct {
    int          src;
    logic [15:0] pkt;
    logic [3:0]  exp_push;
  } vec_t;

  vec_t        vecs[8];
  logic [15:0] src_q[DRV][$];
  logic [19:0] exp_q[$];
  int          total = 0;
  int          bad   = 0;

  // scoreboard compare
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // driver: port FIFO model feeding pndng / D_pop
  function automatic void refresh();
    for (int p = 0; p < DRV; p++) begin
      pndng[0][p] = (src_q[p].size() != 0);
      D_pop[0][p] = (src_q[p].size() != 0) ? src_q[p][0] : 16'h0000;
    end
  endfunction

  task automatic load(input int p, input logic [15:0] pkt);
    src_q[p].push_back(pkt);
    refresh();
  endtask

  // advance to the next falling edge and retire any popped FIFO head
  task automatic tick();
    @(negedge clk);
    for (int p = 0; p < DRV; p++)
      if (pop[0][p] && src_q[p].size() != 0) void'(src_q[p].pop_front());
    refresh();
  endtask

  task automatic wait_pop(output int cyc, output logic [3:0] m);
    cyc = 0;
    m   = 4'b0000;
    while (cyc < 20 && m == 4'b0000) begin
      tick();
      cyc++;
      m = pop[0];
    end
  endtask

  task automatic check_dpush(input string nm, input logic [15:0] exp);
    for (int p = 0; p < DRV; p++)
      check($sformatf("%s_dpush%0d", nm, p), 64'(D_push[0][p]), 64'(exp));
  endtask

  initial begin
    int          cyc;
    logic [3:0]  m;
    logic [19:0] e;
    logic [3:0]  seen;

    vecs[0] = '{0, 16'h0102, 4'b0010};
    vecs[1] = '{3, 16'h0011, 4'b0001};
    vecs[2] = '{1, 16'h0155, 4'b0010};
    vecs[3] = '{2, 16'h03AA, 4'b1000};
    vecs[4] = '{1, 16'h07CD, 4'b0000};
    vecs[5] = '{2, 16'hFFAB, BC_FROM2};
    vecs[6] = '{0, 16'h04EE, 4'b0000};
    vecs[7] = '{3, 16'hFF00, BC_FROM3};

    reset = 1'b1;
    pndng = '0;
    D_pop = '0;

    // reset held 2 cycles with port 0 pending, then first unicast
    load(0, 16'h0102);
    for (int c = 0; c < 2; c++) begin
      tick();
      check($sformatf("rst_pop%0d", c),   64'(pop[0]),     64'h0);
      check($sformatf("rst_push%0d", c),  64'(push[0]),    64'h0);
      check($sformatf("rst_dpush%0d", c), 64'(D_push[0]),  64'h0);
      check($sformatf("rst_state%0d", c), 64'(dbg_state[0]), 64'h0);
    end
    reset = 1'b0;
    wait_pop(cyc, m);
    check("uni_pop", 64'(m), 64'h1);
    check("uni_pop_latency", 64'(cyc), 64'd1);
    tick();
    check("uni_push", 64'(push[0]), 64'h2);
    check("uni_pop_cleared", 64'(pop[0]), 64'h0);
    check_dpush("uni", 16'h0102);
    tick();
    check("uni_push_cleared", 64'(push[0]), 64'h0);

    // round robin across ports 0, 2, 3 after a fresh reset
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      load(0, 16'h0100 + 16'(k));
      load(2, 16'h0120 + 16'(k));
      load(3, 16'h0130 + 16'(k));
    end
    exp_q.push_back(20'd0); exp_q.push_back(20'd2); exp_q.push_back(20'd3);
    exp_q.push_back(20'd0); exp_q.push_back(20'd2); exp_q.push_back(20'd3);
    for (int g = 0; g < 6; g++) begin
      wait_pop(cyc, m);
      e = exp_q.pop_front();
      check($sformatf("rr_grant%0d", g), 64'(m), 64'(4'b0001 << e[1:0]));
      if (g > 0) check($sformatf("rr_gap%0d", g), 64'(cyc), 64'd3);
    end
    tick();
    tick();
    tick();

    // table of single-packet vectors
    for (int i = 0; i < 8; i++) begin
      load(vecs[i].src, vecs[i].pkt);
      exp_q.push_back({vecs[i].exp_push, vecs[i].pkt});
      wait_pop(cyc, m);
      check($sformatf("v%0d_pop", i), 64'(m), 64'(4'b0001 << vecs[i].src));
      check($sformatf("v%0d_latency", i), 64'(cyc), 64'd1);
      tick();
      e = exp_q.pop_front();
      check($sformatf("v%0d_push", i), 64'(push[0]), 64'(e[19:16]));
      check($sformatf("v%0d_pop_cleared", i), 64'(pop[0]), 64'h0);
      if (e[19:16] != 4'b0000) check_dpush($sformatf("v%0d", i), e[15:0]);
      tick();
      check($sformatf("v%0d_push_cleared", i), 64'(push[0]), 64'h0);
    end

    // invalid destination, then the next pending port is served
    load(1, 16'h07CD);
    load(2, 16'h0233);
    wait_pop(cyc, m);
    check("inv_pop", 64'(m), 64'h2);
    tick();
    check("inv_no_push", 64'(push[0]), 64'h0);
    tick();
    wait_pop(cyc, m);
    check("inv_next_pop", 64'(m), 64'h4);
    check("inv_next_latency", 64'(cyc), 64'd1);
    tick();
    check("inv_next_push", 64'(push[0]), 64'h4);
    check_dpush("inv_next", 16'h0233);
    tick();

    // reset during POP, FIFO empty afterwards: nothing more happens
    load(2, 16'h0233);
    wait_pop(cyc, m);
    check("rmid_pop", 64'(m), 64'h4);
    reset = 1'b1;
    tick();
    check("rmid_no_push", 64'(push[0]), 64'h0);
    check("rmid_no_pop", 64'(pop[0]), 64'h0);
    tick();
    reset = 1'b0;
    seen = 4'b0000;
    for (int c = 0; c < 5; c++) begin
      tick();
      seen = seen | pop[0] | push[0];
    end
    check("rmid_idle_after", 64'(seen), 64'h0);

    // reset during POP with the port still pending: packet re-arbitrated
    load(2, 16'h0233);
    load(2, 16'h0233);
    wait_pop(cyc, m);
    check("rmid2_pop", 64'(m), 64'h4);
    reset = 1'b1;
    tick();
    check("rmid2_no_push", 64'(push[0]), 64'h0);
    tick();
    reset = 1'b0;
    wait_pop(cyc, m);
    check("rmid2_repop", 64'(m), 64'h4);
    check("rmid2_repop_latency", 64'(cyc), 64'd1);
    tick();
    check("rmid2_push", 64'(push[0]), 64'h4);
    check_dpush("rmid2", 16'h0233);
    tick();
    check("rmid2_push_cleared", 64'(push[0]), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
